// File: rtl/pio_mailbox_rx.sv
// Receive mailbox fed by an output PIO word in the same clock domain.
// Software toggles bit 31 to post a command; every toggle is one event.
// Data events are queued in a small FIFO that a consumer drains through a
// valid/ready port; command events clear the sticky overflow flag.
module pio_mailbox_rx #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [31:0]   pio_word,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [3:0]    m_addr,
  output logic [15:0]   m_data,
  output logic          ack_toggle,
  output logic [CW-1:0] fifo_count,
  output logic          overflow
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Field decode of the command word.
  logic        word_tog;
  logic        word_clr;
  logic [3:0]  word_addr;
  logic [15:0] word_data;
  logic        unused_word_bits;

  assign word_tog         = pio_word[31];
  assign word_clr         = pio_word[30];
  assign word_addr        = pio_word[19:16];
  assign word_data        = pio_word[15:0];
  assign unused_word_bits = ^pio_word[29:20];

  // State.
  logic          tog_q;
  logic          ack_q,   ack_d;
  logic          ovf_q,   ovf_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [19:0]   mem_q [DEPTH];

  // Event and FIFO control.
  logic event_det;
  logic data_ev;
  logic cmd_ev;
  logic full;
  logic empty;
  logic pop;
  logic push;
  logic drop;

  assign event_det = word_tog ^ tog_q;
  assign data_ev   = event_det & ~word_clr;
  assign cmd_ev    = event_det & word_clr;
  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign pop       = ~empty & m_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push      = data_ev & (~full | pop);
  assign drop      = data_ev & full & ~pop;

  // Next-state for pointers, occupancy, overflow and acknowledge.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    ack_d    = ack_q;

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (cmd_ev)    ovf_d = 1'b0;
    else if (drop) ovf_d = 1'b1;

    if (event_det) ack_d = word_tog;
  end

  // Control registers; reset tracks the live toggle so release is event-free.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tog_q    <= word_tog;
      ack_q    <= word_tog;
      ovf_q    <= 1'b0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      tog_q    <= word_tog;
      ack_q    <= ack_d;
      ovf_q    <= ovf_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage; writes are suppressed while reset is asserted.
  always_ff @(posedge clk) begin
    if (reset_n && push) begin
      mem_q[wr_ptr_q] <= {word_addr, word_data};
    end
  end

  // Head entry presented from storage, forced to zero when empty.
  always_comb begin
    m_valid = ~empty;
    m_addr  = '0;
    m_data  = '0;
    if (!empty) begin
      m_addr = mem_q[rd_ptr_q][19:16];
      m_data = mem_q[rd_ptr_q][15:0];
    end
  end

  assign ack_toggle = ack_q;
  assign fifo_count = count_q;
  assign overflow   = ovf_q;

endmodule

// File: doc/pio_mailbox_rx.md
PIO_MAILBOX_RX -- requirements
Module: pio_mailbox_rx

Interface
REQ-001 Parameter DEPTH, default 4, FIFO depth in entries; SHALL be a power of two from 2 to 16.
REQ-002 Parameter CW, default 3, width of fifo_count; SHALL equal clog2(DEPTH+1).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset_n  input  1  reset; synchronous, active-low.
REQ-005 pio_word  input  32  command word from the output PIO in the same clk domain. Fields: [31] toggle, [30] clear-overflow flag, [19:16] addr, [15:0] data; [29:20] ignored.
REQ-006 m_valid  output  1  head entry is valid on m_addr/m_data.
REQ-007 m_ready  input  1  consumer accepts head entry when m_valid=1 and m_ready=1.
REQ-008 m_addr  output  4  head entry address.
REQ-009 m_data  output  16  head entry data.
REQ-010 ack_toggle  output  1  copy of the last processed toggle value; software polls this through an input PIO.
REQ-011 fifo_count  output  CW  number of occupied entries, 0..DEPTH.
REQ-012 overflow  output  1  sticky flag; an event was dropped because the FIFO was full.

Function
REQ-013 Event definition: an event occurs in cycle N when pio_word[31] != tog_q, where tog_q is a register that samples pio_word[31] every cycle. Detection is combinational on the current pio_word.
REQ-014 Field capture: addr, data and the clear flag SHALL be taken from pio_word in the same cycle N as the event; no separate synchronizer (same clock domain).
REQ-015 Command event (bit30=1): overflow is cleared at edge N+1. Nothing is pushed and fifo_count is unchanged.
REQ-016 Data event (bit30=0) with FIFO not full, or full with a pop in the same cycle: {addr,data} is written at the tail at edge N+1.
REQ-017 Data event (bit30=0) with FIFO full and no pop in the same cycle: the entry is dropped, overflow is set to 1 at edge N+1, and FIFO contents are unchanged.
REQ-018 Acknowledge: ack_toggle SHALL take pio_word[31] at edge N+1 for every event, whether pushed, dropped or a command.
REQ-019 Pop: m_valid=1 and m_ready=1 at an edge removes the head entry.
REQ-020 Outputs are driven from registered FIFO storage. m_valid = (fifo_count != 0). While m_valid=1 and m_ready=0, m_addr and m_data SHALL stay stable.
REQ-021 Latency: a data event in cycle N into an empty FIFO gives m_valid=1 with that entry in cycle N+1. There is no bypass in cycle N.
REQ-022 Simultaneous push and pop: fifo_count is unchanged. With fifo_count=1, the new entry becomes head in the next cycle.
REQ-023 Ordering: entries are popped strictly in push order. Read and write pointers wrap modulo DEPTH.
REQ-024 When m_valid=0, m_addr and m_data SHALL be 0.
REQ-025 m_ready while m_valid=0 is ignored and SHALL NOT change state.

Reset
REQ-026 While reset_n=0 at a clock edge, the following SHALL be set: fifo_count=0, pointers=0, m_valid=0, m_addr=0, m_data=0, overflow=0.
REQ-027 During reset, tog_q and ack_toggle SHALL load pio_word[31], so releasing reset generates no spurious event.
REQ-028 Reset asserted mid-operation discards all FIFO contents and any event in that cycle. No partial write may survive.

Verification
REQ-029 Single event: after reset with pio_word=0, drive pio_word=0x8003_1234. Required: cycle N+1 gives m_valid=1, m_addr=3, m_data=0x1234, ack_toggle=1, fifo_count=1. A pop with m_ready=1 then gives fifo_count=0 and m_valid=0.
REQ-030 Fill and overflow: hold m_ready=0 and issue 5 toggled data events with data 1..5. Required: fifo_count=4 and overflow=1. Draining pops 1,2,3,4 in order; data 5 is absent.
REQ-031 Clear command: with overflow=1, toggle with bit30=1 (e.g. 0x4000_0000 after toggle=1). Required: overflow=0 next cycle, fifo_count unchanged, ack_toggle=0.
REQ-032 Full with simultaneous pop: with fifo_count=4, issue a data event in the same cycle as m_ready=1. Required: fifo_count stays 4, overflow stays 0, and the new entry is popped last.
REQ-033 Backpressure stability: hold m_ready=0 for 10 cycles with m_valid=1 while new events are pushed. Required: m_addr and m_data do not change.
REQ-034 Reset behaviour: assert reset_n=0 for 1 cycle with fifo_count=3 and pio_word[31]=1. Required: fifo_count=0, m_valid=0, overflow=0, ack_toggle=1, and no event after release.
